control_sequencer: RTL

- Multi-cycle hardwired control unit that drives every control input of the CPU datapath: bus-source selects, register load enables, ALU operation, memory strobes and PC increment.
- Sits directly upstream of the datapath. It consumes the latched instruction register and the branch condition flag from the datapath.
- Runs the standard three-step fetch (T0-T2), then an execute sequence selected by opcode IR[31:27], then returns to T0.

---
 rtl/control_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle hardwired control unit for the CPU datapath.
// Runs fetch T0-T2, then an opcode-selected execute sequence, then back to T0.
// Outputs are a pure combinational decode of the state register, IR and CON.
// Ports:
//   clk, clr (async active-low reset), IR (latched instruction), CON (branch flag)
//   bus source selects : PCout ZHighout ZLowout HIout LOout InPortout Cout MDRout BAout
//   register selects   : Gra Grb Grc Rin Rout
//   load enables       : PCin MARin MDRin IRin Yin HIin LOin ZHIin ZLOin CONin
//   misc               : IncPC Read Write operation[OPW-1:0] run
module control_sequencer #(
  parameter int             OPW     = 5,
  parameter logic [OPW-1:0] NOP_OP  = 5'b11010,
  parameter logic [OPW-1:0] HALT_OP = 5'b11011
) (
  input  logic           clk,
  input  logic           clr,
  input  logic [31:0]    IR,
  input  logic           CON,
  output logic           PCout, ZHighout, ZLowout, HIout, LOout, InPortout, Cout, MDRout, BAout,
  output logic           Gra, Grb, Grc, Rin, Rout,
  output logic           PCin, MARin, MDRin, IRin, Yin, HIin, LOin, ZHIin, ZLOin, CONin,
  output logic           IncPC, Read, Write,
  output logic [OPW-1:0] operation,
  output logic           run
);

  localparam logic [3:0] S_RESET = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3,
                         S_T3 = 4'd4, S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7,
                         S_T7 = 4'd8, S_HALT = 4'd9;

  localparam logic [OPW-1:0] OP_LD  = OPW'(0),  OP_LDI = OPW'(1),  OP_ST  = OPW'(2),
                             OP_ADD = OPW'(3),  OP_AND = OPW'(5),  OP_OR  = OPW'(6),
                             OP_ADDI = OPW'(12), OP_ANDI = OPW'(13), OP_ORI = OPW'(14),
                             OP_MUL = OPW'(15), OP_DIV = OPW'(16), OP_BR  = OPW'(18),
                             OP_JR  = OPW'(19);

  logic [3:0]     state_q, state_d, last_st;
  logic [OPW-1:0] opc;
  logic           is_r, is_imm, is_ld, is_ldi, is_st, is_md, is_br, is_jr;

  assign opc    = IR[31 -: OPW];
  assign is_r   = (opc >= OPW'(3)) && (opc <= OPW'(11));
  assign is_imm = (opc == OP_ADDI) || (opc == OP_ANDI) || (opc == OP_ORI);
  assign is_ld  = (opc == OP_LD);
  assign is_ldi = (opc == OP_LDI);
  assign is_st  = (opc == OP_ST);
  assign is_md  = (opc == OP_MUL) || (opc == OP_DIV);
  assign is_br  = (opc == OP_BR);
  assign is_jr  = (opc == OP_JR);

  // Final execute state per class; anything unrecognised (incl. NOP_OP) ends at T2.
  always_comb begin
    last_st = S_T2;
    if (is_r || is_imm || is_ldi)       last_st = S_T5;
    else if (is_ld || is_st)            last_st = S_T7;
    else if (is_md || is_br)            last_st = S_T6;
    else if (is_jr)                     last_st = S_T3;
  end

  always_comb begin
    state_d = S_T0;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_HALT:  state_d = S_HALT;
      default: begin
        if (state_q == S_T2 && opc == HALT_OP) state_d = S_HALT;
        else if (state_q == last_st)           state_d = S_T0;
        else                                   state_d = 4'(state_q + 4'd1);
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= S_RESET;
    else      state_q <= state_d;
  end

  always_comb begin
    {PCout, ZHighout, ZLowout, HIout, LOout, InPortout, Cout, MDRout, BAout} = '0;
    {Gra, Grb, Grc, Rin, Rout} = '0;
    {PCin, MARin, MDRin, IRin, Yin, HIin, LOin, ZHIin, ZLOin, CONin} = '0;
    {IncPC, Read, Write} = '0;
    operation = '0;
    run = (state_q != S_RESET) && (state_q != S_HALT);
    case (state_q)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLOin = 1'b1; end
      S_T1: begin ZLowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        if (is_r || is_imm) begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        else if (is_ld || is_ldi || is_st) begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
        else if (is_md) begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        else if (is_br) begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
        else if (is_jr) begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
      end
      S_T4: begin
        if (is_r) begin Grc = 1'b1; Rout = 1'b1; ZLOin = 1'b1; operation = opc; end
        else if (is_imm) begin
          Cout = 1'b1; ZLOin = 1'b1;
          operation = (opc == OP_ADDI) ? OP_ADD : (opc == OP_ANDI) ? OP_AND : OP_OR;
        end
        else if (is_ld || is_ldi || is_st) begin Cout = 1'b1; ZLOin = 1'b1; operation = OP_ADD; end
        else if (is_md) begin
          Grb = 1'b1; Rout = 1'b1; ZHIin = 1'b1; ZLOin = 1'b1; operation = opc;
        end
        else if (is_br) begin PCout = 1'b1; Yin = 1'b1; end
      end
      S_T5: begin
        if (is_r || is_imm || is_ldi) begin ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (is_ld || is_st) begin ZLowout = 1'b1; MARin = 1'b1; end
        else if (is_md) begin ZLowout = 1'b1; LOin = 1'b1; end
        else if (is_br) begin Cout = 1'b1; ZLOin = 1'b1; operation = OP_ADD; end
      end
      S_T6: begin
        if (is_ld) begin Read = 1'b1; MDRin = 1'b1; end
        else if (is_st) begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
        else if (is_md) begin ZHighout = 1'b1; HIin = 1'b1; end
        // CON only matters here: taken branch loads the computed target.
        else if (is_br && CON) begin ZLowout = 1'b1; PCin = 1'b1; end
      end
      S_T7: begin
        if (is_ld) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (is_st) Write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
